// File: rtl/alarma_pkg.sv
// Shared definitions for the sensor-alarm scan path: level encoding, scheduler states, thresholds.
package alarma_pkg;

  // Confirmed / classified alarm level of one channel.
  typedef enum logic [1:0] {
    LvlAceptable = 2'd0,
    LvlRegular   = 2'd1,
    LvlCritico   = 2'd2
  } level_e;

  // Scan scheduler states.
  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StUpdate,
    StSkip,
    StNext
  } state_e;

  localparam int unsigned DefThReg  = 103;
  localparam int unsigned DefThCrit = 256;

endpackage

// File: rtl/alarma_clasif.sv
// Combinational sum classifier: unsigned sum -> ACEPTABLE / REGULAR / CRITICO.
module alarma_clasif
  import alarma_pkg::*;
#(
  parameter int unsigned W       = 9,
  parameter int unsigned TH_REG  = DefThReg,
  parameter int unsigned TH_CRIT = DefThCrit
) (
  input  logic [W-1:0] sum,
  output logic [1:0]   level
);

  // Widen so thresholds beyond the W-bit range compare correctly (they are simply never reached).
  logic [31:0] sum_ext;
  assign sum_ext = 32'(sum);

  // Threshold compare, highest band first.
  always_comb begin
    level = LvlAceptable;
    if (sum_ext >= TH_CRIT) begin
      level = LvlCritico;
    end else if (sum_ext >= TH_REG) begin
      level = LvlRegular;
    end
  end

endmodule

// File: rtl/alarma_scheduler.sv
// Round-robin channel scan: fetches each channel sum over req/valid, confirms level changes over
// CONFIRM equal samples, latches critical alarms until acknowledged, flags missed samples.
module alarma_scheduler
  import alarma_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned W       = 9,
  parameter int unsigned TH_REG  = DefThReg,
  parameter int unsigned TH_CRIT = DefThCrit,
  parameter int unsigned CONFIRM = 3,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned ChW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic [ChW-1:0]      ch_sel,
  output logic                sample_req,
  input  logic                sample_valid,
  input  logic [W-1:0]        sum_in,
  input  logic [N_CH-1:0]     ack,
  output logic [2*N_CH-1:0]   level,
  output logic [N_CH-1:0]     crit_latch,
  output logic [N_CH-1:0]     fault,
  output logic                alarm_any,
  output logic                scan_done
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW = $clog2(CONFIRM + 1);

  state_e          state_q, state_d;
  logic [ChW-1:0]  ch_q;
  logic [TmoW-1:0] tmo_q;
  logic [W-1:0]    samp_q;
  logic [1:0]      cls;

  alarma_clasif #(
    .W       (W),
    .TH_REG  (TH_REG),
    .TH_CRIT (TH_CRIT)
  ) u_clasif (
    .sum   (samp_q),
    .level (cls)
  );

  // Next-state logic; a valid in the expiring REQ cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (en) state_d = StReq;
      StReq: begin
        if (sample_valid) begin
          state_d = StUpdate;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          state_d = StSkip;
        end
      end
      StUpdate: state_d = StNext;
      StSkip:   state_d = StNext;
      StNext:   state_d = en ? StReq : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, channel pointer, REQ timeout counter and captured sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ch_q    <= '0;
      tmo_q   <= '0;
      samp_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StReq) begin
        tmo_q <= tmo_q + TmoW'(1);
        if (sample_valid) samp_q <= sum_in;
      end else begin
        tmo_q <= '0;
      end
      if (state_q == StNext) begin
        ch_q <= (ch_q == ChW'(N_CH - 1)) ? '0 : ch_q + ChW'(1);
      end
    end
  end

  assign ch_sel     = ch_q;
  assign sample_req = (state_q == StReq);
  assign scan_done  = (state_q == StNext) && (ch_q == ChW'(N_CH - 1));
  assign alarm_any  = |crit_latch;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]      cand_q, cand_d, lvl_q, lvl_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            crit_q, crit_d, fault_q, fault_d;
    logic            hit;

    assign hit = (ch_q == ChW'(i));

    // Confirmation filter, fault tracking and sticky critical flag for this channel.
    always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      fault_d = fault_q;
      if (hit && state_q == StUpdate) begin
        fault_d = 1'b0;
        if (cls == cand_q) begin
          if (cnt_q != CntW'(CONFIRM)) cnt_d = cnt_q + CntW'(1);
        end else begin
          cand_d = cls;
          cnt_d  = CntW'(1);
        end
        if (cnt_d == CntW'(CONFIRM)) lvl_d = cand_d;
      end else if (hit && state_q == StSkip) begin
        fault_d = 1'b1;
      end
      crit_d = crit_q;
      // Ack only releases a latch whose confirmed level has already left CRITICO.
      if (ack[i] && lvl_q != LvlCritico) crit_d = 1'b0;
      if (lvl_d == LvlCritico) crit_d = 1'b1;
    end

    // Per-channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cand_q  <= LvlAceptable;
        cnt_q   <= '0;
        lvl_q   <= LvlAceptable;
        crit_q  <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        cand_q  <= cand_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        crit_q  <= crit_d;
        fault_q <= fault_d;
      end
    end

    assign level[2*i +: 2] = lvl_q;
    assign crit_latch[i]   = crit_q;
    assign fault[i]        = fault_q;
  end

endmodule

// File: tb/tb_alarma_scheduler.sv
// Directed bench for alarma_scheduler with a transaction-level reference model.
module tb_alarma_scheduler;

  localparam int N       = 4;
  localparam int CONFIRM = 3;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n, en, sample_valid;
  logic [8:0] sum_in;
  logic [3:0] ack;
  logic [1:0] ch_sel;
  logic       sample_req, alarm_any, scan_done;
  logic [7:0] level;
  logic [3:0] crit_latch, fault;

  alarma_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .ch_sel       (ch_sel),
    .sample_req   (sample_req),
    .sample_valid (sample_valid),
    .sum_in       (sum_in),
    .ack          (ack),
    .level        (level),
    .crit_latch   (crit_latch),
    .fault        (fault),
    .alarm_any    (alarm_any),
    .scan_done    (scan_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: last CONFIRM classes per channel, confirmed level, flags.
  int       hist  [N][CONFIRM];
  int       nhist [N];
  int       m_level [N];
  logic [3:0] m_crit, m_fault;
  int       pend_kind, pend_ch, pend_sum;
  int       exp_ch;
  bit       run = 1'b0;
  int       sd_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input int s);
    if (s < 103) return 0;
    if (s < 256) return 1;
    return 2;
  endfunction

  function automatic logic [7:0] m_level_vec();
    logic [7:0] v;
    for (int i = 0; i < N; i++) v[2*i +: 2] = 2'(m_level[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      nhist[i]   = 0;
      m_level[i] = 0;
      for (int k = 0; k < CONFIRM; k++) hist[i][k] = 0;
    end
    m_crit    = '0;
    m_fault   = '0;
    pend_kind = 0;
  endtask

  // Model advances on the edge where the DUT commits an UPDATE or SKIP.
  always @(posedge clk) begin
    if (rst_n && run) begin
      for (int i = 0; i < N; i++) if (ack[i] && m_level[i] != 2) m_crit[i] = 1'b0;
      if (pend_kind == 1) begin
        int old_lvl;
        bit same;
        old_lvl = m_level[pend_ch];
        for (int k = CONFIRM - 1; k > 0; k--) hist[pend_ch][k] = hist[pend_ch][k-1];
        hist[pend_ch][0] = classify(pend_sum);
        if (nhist[pend_ch] < CONFIRM) nhist[pend_ch]++;
        same = 1'b1;
        for (int k = 1; k < CONFIRM; k++) if (hist[pend_ch][k] != hist[pend_ch][0]) same = 1'b0;
        if (nhist[pend_ch] == CONFIRM && same) m_level[pend_ch] = hist[pend_ch][0];
        if (m_level[pend_ch] == 2 && old_lvl != 2) m_crit[pend_ch] = 1'b1;
        m_fault[pend_ch] = 1'b0;
      end else if (pend_kind == 2) begin
        m_fault[pend_ch] = 1'b1;
      end
      pend_kind = 0;
    end
  end

  // Cycle-by-cycle comparison of the status outputs against the model.
  always @(negedge clk) begin
    if (run) begin
      check("level", level, m_level_vec());
      check("crit_latch", crit_latch, m_crit);
      check("fault", fault, m_fault);
      check("alarm_any", alarm_any, |m_crit);
      if (scan_done === 1'b1) sd_count++;
    end
  end

  task automatic wait_req();
    int t;
    t = 0;
    while (sample_req !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sample_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_wait: sample_req got %b, expected 1 within 40 cycles", sample_req);
    end
  endtask

  // Serve the channel currently requested: valid after 'gap' REQ cycles, or never (timeout).
  task automatic serve(input int gap, input bit give, input int sum);
    int n;
    wait_req();
    check("ch_sel", ch_sel, exp_ch);
    if (give) begin
      repeat (gap) @(negedge clk);
      check("req_before_valid", sample_req, 1);
      sample_valid = 1'b1;
      sum_in       = 9'(sum);
      @(negedge clk);
      sample_valid = 1'b0;
      pend_ch   = exp_ch;
      pend_sum  = sum;
      pend_kind = 1;
    end else begin
      n = 0;
      for (int k = 0; k < TIMEOUT; k++) begin
        if (sample_req === 1'b1) n++;
        @(negedge clk);
      end
      check("req_cycles", n, TIMEOUT);
      check("req_dropped", sample_req, 0);
      pend_ch   = exp_ch;
      pend_kind = 2;
    end
    exp_ch = (exp_ch + 1) % N;
  endtask

  task automatic scan(input int s0, input int s1, input int s2, input int s3);
    serve(0, 1'b1, s0);
    serve(1, 1'b1, s1);
    serve(2, 1'b1, s2);
    serve(3, 1'b1, s3);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; sample_valid = 1'b0; sum_in = '0; ack = '0;
    model_reset();
    exp_ch = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_req", sample_req, 0);
    check("rst_level", level, 0);
    check("rst_crit", crit_latch, 0);
    check("rst_fault", fault, 0);
    check("rst_scan_done", scan_done, 0);
    rst_n = 1'b1;
    run   = 1'b1;
    en    = 1'b1;

    // Build up state, then reset in the middle of channel 2's request.
    scan(50, 300, 50, 50);
    scan(50, 300, 50, 50);
    serve(0, 1'b1, 50);
    serve(1, 1'b1, 300);
    wait_req();
    check("pre_rst_ch_sel", ch_sel, 2);
    check("pre_rst_level1", level[3:2], 2);
    check("pre_rst_crit", crit_latch, 4'b0010);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ch_sel", ch_sel, 0);
    check("mid_rst_req", sample_req, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_crit", crit_latch, 0);
    check("mid_rst_alarm", alarm_any, 0);
    model_reset();
    exp_ch = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Confirmation: steady inputs settle, alternating input on ch2 never confirms.
    scan(103, 300, 300, 256);
    scan(103, 300,  80, 256);
    scan(103, 300, 300, 256);
    @(negedge clk);
    check("scan3_level", level, 8'h89);
    check("scan3_crit", crit_latch, 4'b1010);
    check("scan3_done", scan_done, 1);

    // Ack held on ch1: ignored while CRITICO, releases once level drops.
    ack = 4'b0010;
    scan(102, 40, 256, 255);
    scan(102, 40, 256, 255);
    check("ack_ignored", crit_latch[1], 1);
    scan(102, 40, 256, 255);
    @(negedge clk);
    check("scan6_level", level, 8'h60);
    check("scan6_crit", crit_latch, 4'b1100);

    // Timeout on ch3.
    ack = 4'b1010;
    serve(0, 1'b1, 50);
    serve(1, 1'b1, 50);
    serve(2, 1'b1, 256);
    serve(0, 1'b0, 0);
    @(negedge clk);
    check("skip_scan_done", scan_done, 1);
    check("skip_fault", fault, 4'b1000);
    @(negedge clk);
    check("wrap_ch_sel", ch_sel, 0);
    check("wrap_scan_done", scan_done, 0);
    check("wrap_req", sample_req, 1);
    check("ack3_crit", crit_latch, 4'b0100);
    ack = '0;

    // Valid on the very last REQ cycle is still taken; ch3 recovers.
    serve(TIMEOUT - 1, 1'b1, 50);
    serve(1, 1'b1, 50);
    serve(0, 1'b1, 256);
    serve(1, 1'b1, 255);
    @(negedge clk);
    check("recover_fault", fault, 0);

    // en dropped during ch1's request: ch1 completes, then the scan parks.
    serve(0, 1'b1, 50);
    wait_req();
    en = 1'b0;
    serve(2, 1'b1, 50);
    repeat (2) @(negedge clk);
    check("park_req", sample_req, 0);
    check("park_ch_sel", ch_sel, 2);
    repeat (4) @(negedge clk);
    check("park_req_hold", sample_req, 0);
    check("park_ch_hold", ch_sel, 2);
    en = 1'b1;
    serve(0, 1'b1, 50);
    serve(1, 1'b1, 255);
    repeat (3) @(negedge clk);
    check("scan_done_count", sd_count, 11);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
